// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// responder state type, byte-lane count and funct3 legality helper.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int unsigned LANES = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Stores only know sb/sh/sw; loads additionally have the unsigned forms.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      if (we)
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      else
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the processor memory
// stage (master) and the data-memory responder (slave).
interface dmem_responder_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [2:0]  req_f3;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_f3, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_f3, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store lane mask and replicated store
// word, extended load data, and size-alignment check for one access.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]       i_addr,
   input  logic [2:0]       i_f3,
   input  logic [31:0]      i_wdata,
   input  logic [31:0]      i_raw,
   output logic [LANES-1:0] o_mask,
   output logic [31:0]      o_wword,
   output logic [31:0]      o_ldata,
   output logic             o_misalign
);

   logic [31:0] w_shift;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Select the addressed byte/half of the raw word and extend it.
   always_comb begin
      w_shift = i_raw >> {i_addr, 3'b000};
      w_byte  = w_shift[7:0];
      w_half  = i_addr[1] ? i_raw[31:16] : i_raw[15:0];
      case (i_f3)
         F3_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_ldata = {24'h000000, w_byte};
         F3_H:    o_ldata = {{16{w_half[15]}}, w_half};
         F3_HU:   o_ldata = {16'h0000, w_half};
         F3_W:    o_ldata = i_raw;
         default: o_ldata = '0;
      endcase
   end

   // Store data is replicated across lanes so the mask alone picks the target.
   always_comb begin
      case (i_f3)
         F3_B: begin
            o_mask  = 4'b0001 << i_addr;
            o_wword = {4{i_wdata[7:0]}};
         end
         F3_H: begin
            o_mask  = i_addr[1] ? 4'b1100 : 4'b0011;
            o_wword = {2{i_wdata[15:0]}};
         end
         F3_W: begin
            o_mask  = 4'b1111;
            o_wword = i_wdata;
         end
         default: begin
            o_mask  = '0;
            o_wword = '0;
         end
      endcase
   end

   // Halves need an even address, words a multiple of four.
   always_comb begin
      o_misalign = ((i_f3[1:0] == 2'b01) && i_addr[0]) ||
                   ((i_f3[1:0] == 2'b10) && (i_addr != 2'b00));
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts
// WAIT_CYCLES wait states, then performs the access and holds the response
// until the processor takes it.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 1
)
(
   input  logic       clk,
   input  logic       reset,
   dmem_responder_if.slave bus
);

   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  LAST = 4'(WAIT_CYCLES);

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic              r_we;
   logic [31:0]       r_addr;
   logic [2:0]        r_f3;
   logic [31:0]       r_wdata;
   logic              r_req_ready;
   logic              r_rsp_valid;
   logic [31:0]       r_rdata;
   logic              r_err;
   logic [31:0]       r_mem [DEPTH];

   logic [AW-1:0]     w_idx;
   logic              w_in_range;
   logic [31:0]       w_raw;
   logic [LANES-1:0]  w_mask;
   logic [31:0]       w_wword;
   logic [31:0]       w_ldata;
   logic              w_misalign;
   logic              w_err;
   logic              w_do_access;
   logic              w_write;

   dmem_lane_align u_align (
      .i_addr     (r_addr[1:0]),
      .i_f3       (r_f3),
      .i_wdata    (r_wdata),
      .i_raw      (w_raw),
      .o_mask     (w_mask),
      .o_wword    (w_wword),
      .o_ldata    (w_ldata),
      .o_misalign (w_misalign)
   );

   // Decode the captured request: word index, range, fault and access strobe.
   always_comb begin
      w_idx       = r_addr[AW+1:2];
      w_in_range  = ({2'b00, r_addr[31:2]} < DEPTH);
      w_raw       = w_in_range ? r_mem[w_idx] : '0;
      w_err       = !w_in_range || !f3_legal(r_we, r_f3) || w_misalign;
      w_do_access = (r_state == WAIT) && (r_cnt == LAST);
      w_write     = w_do_access && r_we && !w_err && !reset;
   end

   // Byte-lane write on the edge entering RESP; contents survive reset.
   always_ff @(posedge clk) begin
      if (w_write) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (w_mask[i])
               r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
         end
      end
   end

   // Request/response FSM with registered handshake and response outputs.
   // WAIT always holds at least one cycle so the access works from the
   // captured request; the counter then adds WAIT_CYCLES further cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_f3        <= '0;
         r_wdata     <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.req_valid && r_req_ready) begin
                  r_we        <= bus.req_we;
                  r_addr      <= bus.req_addr;
                  r_f3        <= bus.req_f3;
                  r_wdata     <= bus.req_wdata;
                  r_req_ready <= 1'b0;
                  r_cnt       <= '0;
                  r_state     <= WAIT;
               end
            end
            WAIT: begin
               if (w_do_access) begin
                  r_state     <= RESP;
                  r_rsp_valid <= 1'b1;
                  r_err       <= w_err;
                  r_rdata     <= (w_err || r_we) ? '0 : w_ldata;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  r_state     <= IDLE;
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_rsp_valid <= 1'b0;
               r_req_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.req_ready = r_req_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rdata;
   assign bus.rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (one and three wait states), a
// byte-array reference model per instance compared every cycle, and
// directed transactions with hand-computed results.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int unsigned DEPTH = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        drv_reset     [2];
   logic        drv_valid     [2];
   logic        drv_we        [2];
   logic [31:0] drv_addr      [2];
   logic [2:0]  drv_f3        [2];
   logic [31:0] drv_wdata     [2];
   logic        drv_rsp_ready [2];

   logic        o_req_ready [2];
   logic        o_rsp_valid [2];
   logic [31:0] o_rdata     [2];
   logic        o_err       [2];
   bit          cmp_en      [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int unsigned W = (gi == 0) ? 1 : 3;

      dmem_responder_if bus ();

      assign bus.req_valid = drv_valid[gi];
      assign bus.req_we    = drv_we[gi];
      assign bus.req_addr  = drv_addr[gi];
      assign bus.req_f3    = drv_f3[gi];
      assign bus.req_wdata = drv_wdata[gi];
      assign bus.rsp_ready = drv_rsp_ready[gi];
      assign o_req_ready[gi] = bus.req_ready;
      assign o_rsp_valid[gi] = bus.rsp_valid;
      assign o_rdata[gi]     = bus.rsp_rdata;
      assign o_err[gi]       = bus.rsp_err;

      dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
         .clk   (clk),
         .reset (drv_reset[gi]),
         .bus   (bus)
      );

      // Reference model: memory as a flat byte array, handshake as timestamps.
      logic [7:0]  mb [0:DEPTH*4-1];
      bit          m_ready, m_valid, m_rst, m_pend, m_err;
      logic [31:0] m_rdata;
      int          cd;
      bit          q_we;
      logic [31:0] q_addr, q_wdata;
      logic [2:0]  q_f3;

      function automatic void access(input bit we, input logic [31:0] a,
                                     input logic [2:0] f3, input logic [31:0] wd,
                                     output logic [31:0] rd, output bit er);
         int unsigned size;
         bit legal;
         logic [31:0] v;
         legal = we ? (f3 inside {3'd0, 3'd1, 3'd2})
                    : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
         size = 1 << f3[1:0];
         er = !legal || ((a % size) != 0) || ((a >> 2) >= DEPTH);
         rd = '0;
         if (!er) begin
            if (we) begin
               for (int unsigned i = 0; i < size; i++) mb[a + i] = wd[8*i +: 8];
            end else begin
               v = '0;
               for (int unsigned i = 0; i < size; i++) v[8*i +: 8] = mb[a + i];
               if (!f3[2] && size < 4 && v[8*size-1])
                  for (int unsigned i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
               rd = v;
            end
         end
      endfunction

      always @(posedge clk) begin
         if (drv_reset[gi]) begin
            m_ready = 1; m_valid = 0; m_rst = 1; m_pend = 0;
            m_rdata = '0; m_err = 0;
         end else if (m_valid) begin
            if (drv_rsp_ready[gi]) begin m_valid = 0; m_ready = 1; end
         end else if (m_pend) begin
            cd--;
            if (cd == 0) begin
               access(q_we, q_addr, q_f3, q_wdata, m_rdata, m_err);
               m_pend = 0; m_valid = 1; m_rst = 0;
            end
         end else if (m_ready && drv_valid[gi]) begin
            q_we = drv_we[gi]; q_addr = drv_addr[gi];
            q_f3 = drv_f3[gi]; q_wdata = drv_wdata[gi];
            m_ready = 0; m_pend = 1; cd = int'(W) + 1;
         end
      end

      always @(negedge clk) begin
         if (cmp_en[gi]) begin
            chk($sformatf("m%0d_req_ready", gi), 32'(o_req_ready[gi]), 32'(m_ready));
            chk($sformatf("m%0d_rsp_valid", gi), 32'(o_rsp_valid[gi]), 32'(m_valid));
            if (m_valid || m_rst) begin
               chk($sformatf("m%0d_rdata", gi), o_rdata[gi], m_rdata);
               chk($sformatf("m%0d_err", gi), 32'(o_err[gi]), 32'(m_err));
            end
         end
      end
   end

   // Present a request at a falling edge and hold it until accepted.
   task automatic send(input int k, input bit we, input logic [31:0] a,
                       input logic [2:0] f3, input logic [31:0] wd);
      int t = 0;
      drv_we[k] = we; drv_addr[k] = a; drv_f3[k] = f3; drv_wdata[k] = wd;
      drv_valid[k] = 1'b1;
      while (o_req_ready[k] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin
         checks++; errors++;
         $display("FAIL accept_timeout inst=%0d actual=no_accept required=accept", k);
      end
      @(posedge clk);
      @(negedge clk);
      drv_valid[k] = 1'b0;
   endtask

   task automatic wait_rsp(input int k, output int lat);
      lat = 0;
      while (o_rsp_valid[k] !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
   endtask

   task automatic xact(input int k, input bit we, input logic [31:0] a,
                       input logic [2:0] f3, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input bit exp_er, input string nm);
      int lat;
      send(k, we, a, f3, wd);
      wait_rsp(k, lat);
      chk({nm, "_lat"}, 32'(lat), (k == 0) ? 32'd2 : 32'd4);
      chk({nm, "_rdata"}, o_rdata[k], exp_rd);
      chk({nm, "_err"}, 32'(o_err[k]), 32'(exp_er));
      @(negedge clk);
   endtask

   task automatic chk_reset_vals(input int k, input string nm);
      chk({nm, "_req_ready"}, 32'(o_req_ready[k]), 32'd1);
      chk({nm, "_rsp_valid"}, 32'(o_rsp_valid[k]), 32'd0);
      chk({nm, "_rdata"}, o_rdata[k], 32'd0);
      chk({nm, "_err"}, 32'(o_err[k]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      for (int k = 0; k < 2; k++) begin
         drv_reset[k] = 1'b1; drv_valid[k] = 1'b0; drv_we[k] = 1'b0;
         drv_addr[k] = '0; drv_f3[k] = '0; drv_wdata[k] = '0;
         drv_rsp_ready[k] = 1'b1; cmp_en[k] = 1'b0;
      end
      repeat (2) @(negedge clk);
      chk_reset_vals(0, "rst0");
      chk_reset_vals(1, "rst1");
      cmp_en[0] = 1'b1; cmp_en[1] = 1'b1;
      drv_reset[0] = 1'b0; drv_reset[1] = 1'b0;
      @(negedge clk);

      // One wait state: word, sub-word, byte merge and fault cases.
      xact(0, 1, 32'h10, F3_W,  32'hDEADBEEF, 32'h0,        0, "sw10");
      xact(0, 0, 32'h10, F3_W,  32'h0,        32'hDEADBEEF, 0, "lw10");
      xact(0, 0, 32'h13, F3_B,  32'h0,        32'hFFFFFFDE, 0, "lb13");
      xact(0, 0, 32'h13, F3_BU, 32'h0,        32'h000000DE, 0, "lbu13");
      xact(0, 0, 32'h10, F3_H,  32'h0,        32'hFFFFBEEF, 0, "lh10");
      xact(0, 0, 32'h12, F3_HU, 32'h0,        32'h0000DEAD, 0, "lhu12");
      xact(0, 1, 32'h11, F3_B,  32'h00000055, 32'h0,        0, "sb11");
      xact(0, 0, 32'h10, F3_W,  32'h0,        32'hDEAD55EF, 0, "lw10b");
      xact(0, 0, 32'h12, F3_W,  32'h0,        32'h0,        1, "lw12_mis");
      xact(0, 1, 32'h0C, F3_W,  32'h12345678, 32'h0,        0, "sw0c");
      xact(0, 1, 32'h0F, F3_H,  32'h0000AAAA, 32'h0,        1, "sh0f_mis");
      xact(0, 0, 32'h0C, F3_W,  32'h0,        32'h12345678, 0, "lw0c");
      xact(0, 0, DEPTH*4, F3_W, 32'h0,        32'h0,        1, "lw_range");
      xact(0, 0, 32'h10, 3'b011, 32'h0,       32'h0,        1, "ld_f3_011");
      xact(0, 1, 32'h10, F3_BU, 32'h000000AA, 32'h0,        1, "st_f3_100");
      xact(0, 1, 32'h14, F3_W,  32'hCAFEF00D, 32'h0,        0, "sw14");

      // Response back-pressure with a second request waiting behind it.
      drv_rsp_ready[0] = 1'b0;
      send(0, 0, 32'h10, F3_W, 32'h0);
      drv_addr[0] = 32'h14; drv_valid[0] = 1'b1;
      wait_rsp(0, lat);
      chk("stall_lat", 32'(lat), 32'd2);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("stall_valid", 32'(o_rsp_valid[0]), 32'd1);
         chk("stall_rdata", o_rdata[0], 32'hDEAD55EF);
         chk("stall_req_ready", 32'(o_req_ready[0]), 32'd0);
      end
      drv_rsp_ready[0] = 1'b1;
      @(negedge clk);
      chk("release_req_ready", 32'(o_req_ready[0]), 32'd1);
      chk("release_rsp_valid", 32'(o_rsp_valid[0]), 32'd0);
      @(negedge clk);
      drv_valid[0] = 1'b0;
      chk("second_accepted", 32'(o_req_ready[0]), 32'd0);
      wait_rsp(0, lat);
      chk("second_lat", 32'(lat), 32'd2);
      chk("second_rdata", o_rdata[0], 32'hCAFEF00D);
      @(negedge clk);

      // Three wait states: reset two cycles after accept cancels the store.
      xact(1, 1, 32'h20, F3_W, 32'h11112222, 32'h0,        0, "w3_sw20");
      xact(1, 0, 32'h20, F3_W, 32'h0,        32'h11112222, 0, "w3_lw20");
      send(1, 1, 32'h20, F3_W, 32'h99998888);
      @(negedge clk);
      drv_reset[1] = 1'b1;
      @(negedge clk);
      chk_reset_vals(1, "midrst");
      drv_reset[1] = 1'b0;
      repeat (4) @(negedge clk);
      xact(1, 0, 32'h20, F3_W, 32'h0, 32'h11112222, 0, "w3_after_rst");

      // Reset on the very edge that would enter RESP also suppresses the write.
      send(1, 1, 32'h20, F3_W, 32'h77776666);
      repeat (3) @(negedge clk);
      drv_reset[1] = 1'b1;
      @(negedge clk);
      chk_reset_vals(1, "edgerst");
      drv_reset[1] = 1'b0;
      repeat (2) @(negedge clk);
      xact(1, 0, 32'h20, F3_W, 32'h0, 32'h11112222, 0, "w3_after_edgerst");

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
